// File: rtl/serial_addsub_pkg.sv
// Shared types and limits for the bit-serial add/subtract unit.
package serial_addsub_pkg;

  // Control states: waiting for operands, shifting bits, holding the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } addsub_state_t;

  // Widest operand the unit is intended to be built with.
  localparam int MAX_WIDTH = 64;

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// One-bit combinational full adder; the only arithmetic in the serial unit.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum and carry of three one-bit inputs.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (cin & (a ^ b));
  end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell plus a carry
// flip-flop, one bit per clock, LSB first.
//
// Handshakes (both sides): a transfer happens on a rising clock edge where
// valid && ready are both high. start_ready depends on state only (high in
// IDLE). done_valid is high in DONE and is never withdrawn until done_ready
// is seen; while it waits, sum/cout/ovf are held.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy,
  output addsub_state_t    state_dbg
);

  // Counter needs to hold 0..WIDTH-1; exit happens at WIDTH-1 so it never wraps.
  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("serial_addsub: WIDTH out of range");
  end

  addsub_state_t    state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_s;
  logic             fa_co;

  // The single arithmetic cell works on the current LSBs and the stored carry.
  fa_cell u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  // Next-state and datapath update for the three-state controller.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          // Subtraction is a + ~b + 1, so invert B and force the carry in.
          a_sr_d  = a;
          b_sr_d  = b ^ {WIDTH{sub}};
          carry_d = sub | cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_sr_d  = WIDTH'({fa_s, s_sr_q} >> 1);
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          // On the MSB, carry_q is the carry into the MSB and fa_co the one out.
          ovf_d   = carry_q ^ fa_co;
          cout_d  = fa_co;
          state_d = DONE;
        end
      end
      DONE: begin
        if (done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs decoded from state; result fields are only shown while in DONE.
  always_comb begin
    start_ready = (state_q == IDLE);
    done_valid  = (state_q == DONE);
    busy        = (state_q != IDLE);
    sum         = done_valid ? s_sr_q : '0;
    cout        = done_valid & cout_q;
    ovf         = done_valid & ovf_q;
    state_dbg   = state_q;
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: directed and random WIDTH=8 cases, plus exhaustive
// back-to-back runs on WIDTH=1 and WIDTH=4 instances.
module tb_serial_addsub;
  import serial_addsub_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst8_n;
  logic rst_s_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: returns {cout, ovf, sum[63:0]} for a w-bit operation.
  function automatic logic [65:0] model(input int w, input logic [63:0] av,
                                        input logic [63:0] bv, input logic ci,
                                        input logic su);
    logic [64:0] mask;
    logic [64:0] full;
    logic [63:0] am, bm, s;
    logic        c, co, ov;
    mask = (65'd1 << w) - 65'd1;
    am   = av & mask[63:0];
    bm   = (su ? ~bv : bv) & mask[63:0];
    c    = su ? 1'b1 : ci;
    full = {1'b0, am} + {1'b0, bm} + {64'd0, c};
    s    = full[63:0] & mask[63:0];
    co   = full[w];
    ov   = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
    return {co, ov, s};
  endfunction

  // ---------------- WIDTH=8 instance ----------------
  logic          start_valid, start_ready, sub, cin, cout, ovf;
  logic          done_valid, done_ready, busy;
  logic [W-1:0]  a, b, sum;
  addsub_state_t state8;

  serial_addsub #(.WIDTH(W)) u_dut (
    .clk         (clk),
    .reset_n     (rst8_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .sub         (sub),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .sum         (sum),
    .cout        (cout),
    .ovf         (ovf),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .busy        (busy),
    .state_dbg   (state8)
  );

  logic [W+1:0] exp_q[$];
  int           acc_q[$];
  logic         dv8_prev = 1'b0;

  // Scoreboard for the 8-bit unit: latency on rise, result on handshake.
  always @(negedge clk) begin
    if (done_valid && !dv8_prev) begin
      if (acc_q.size() > 0) check("w8_latency", 64'(cyc - acc_q.pop_front()), 64'(W));
      else                  check("w8_spurious_done", {63'd0, done_valid}, 64'd0);
    end
    if (done_valid && done_ready) begin
      if (exp_q.size() > 0) check("w8_result", {54'd0, cout, ovf, sum}, {54'd0, exp_q.pop_front()});
      else                  check("w8_extra_result", {63'd0, done_valid}, 64'd0);
    end
    dv8_prev <= done_valid;
  end

  // Offer one request, record its expectation, then scramble the inputs.
  task automatic send8(input logic [7:0] ai, input logic [7:0] bi, input logic ci, input logic si);
    int          n;
    logic [65:0] r;
    @(negedge clk);
    a = ai; b = bi; cin = ci; sub = si; start_valid = 1'b1;
    n = 0;
    while (!start_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!start_ready) check("w8_start_ready_wait", {63'd0, start_ready}, 64'd1);
    r = model(W, {56'd0, ai}, {56'd0, bi}, ci, si);
    exp_q.push_back({r[65:64], r[W-1:0]});
    acc_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
    sub = 1'($urandom);
  endtask

  task automatic wait_drain8();
    for (int k = 0; k < 60 && exp_q.size() > 0; k++) @(negedge clk);
    check("w8_drain", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- WIDTH=1 and WIDTH=4 instances ----------------
  for (genvar g = 0; g < 2; g++) begin : g_small
    localparam int WS = (g == 0) ? 1 : 4;
    logic          sv, sr, su, ci, co, ov, dv, dr, bz;
    logic [WS-1:0] aa, bb, sm;
    addsub_state_t st;
    logic [WS+1:0] eq[$];
    int            aq[$];
    logic          dvp = 1'b0;
    logic          fin = 1'b0;

    serial_addsub #(.WIDTH(WS)) u_dut (
      .clk         (clk),
      .reset_n     (rst_s_n),
      .start_valid (sv),
      .start_ready (sr),
      .sub         (su),
      .a           (aa),
      .b           (bb),
      .cin         (ci),
      .sum         (sm),
      .cout        (co),
      .ovf         (ov),
      .done_valid  (dv),
      .done_ready  (dr),
      .busy        (bz),
      .state_dbg   (st)
    );

    // Exhaustive back-to-back driver over sub, cin, a, b.
    initial begin
      sv = 1'b0; su = 1'b0; ci = 1'b0; aa = '0; bb = '0; dr = 1'b1;
      wait (rst_s_n === 1'b1);
      for (int m = 0; m < 4 * (1 << (2 * WS)); m++) begin
        logic [65:0] r;
        int          n;
        @(negedge clk);
        {su, ci, aa, bb} = m[2*WS+1:0];
        sv = 1'b1;
        n = 0;
        while (!sr && n < 4 * WS + 8) begin
          @(negedge clk);
          n++;
        end
        if (!sr) check($sformatf("w%0d_start_ready_wait", WS), {63'd0, sr}, 64'd1);
        r = model(WS, 64'(aa), 64'(bb), ci, su);
        eq.push_back({r[65:64], r[WS-1:0]});
        aq.push_back(cyc + 1);
        @(posedge clk);
      end
      @(negedge clk);
      sv = 1'b0;
      for (int k = 0; k < 40 && eq.size() > 0; k++) @(negedge clk);
      check($sformatf("w%0d_drain", WS), 64'(eq.size()), 64'd0);
      fin = 1'b1;
    end

    // Scoreboard for the small instance.
    always @(negedge clk) begin
      if (dv && !dvp) begin
        if (aq.size() > 0) check($sformatf("w%0d_latency", WS), 64'(cyc - aq.pop_front()), 64'(WS));
        else               check($sformatf("w%0d_spurious_done", WS), {63'd0, dv}, 64'd0);
      end
      if (dv && dr) begin
        check($sformatf("w%0d_state", WS), {61'd0, bz, st}, {61'd0, 1'b1, DONE});
        if (eq.size() > 0) check($sformatf("w%0d_result", WS), 64'({co, ov, sm}), 64'(eq.pop_front()));
        else               check($sformatf("w%0d_extra_result", WS), {63'd0, dv}, 64'd0);
      end
      dvp <= dv;
    end
  end

  // ---------------- main sequence ----------------
  logic [7:0] ta[7] = '{8'h05, 8'hFF, 8'h7F, 8'hFF, 8'h05, 8'h80, 8'h10};
  logic [7:0] tb[7] = '{8'h03, 8'h01, 8'h01, 8'hFF, 8'h07, 8'h01, 8'h10};
  logic       tc[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic       ts[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    logic [65:0] r;
    int          n;
    rst8_n = 1'b0; rst_s_n = 1'b0;
    start_valid = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0; done_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst8_n = 1'b1; rst_s_n = 1'b1;
    #1;
    check("rst_start_ready", {63'd0, start_ready}, 64'd1);
    check("rst_done_valid",  {63'd0, done_valid},  64'd0);
    check("rst_busy",        {63'd0, busy},        64'd0);
    check("rst_sum",         {56'd0, sum},         64'd0);
    check("rst_cout_ovf",    {62'd0, cout, ovf},   64'd0);
    check("rst_state",       {62'd0, state8},      {62'd0, IDLE});

    // Directed corner cases, one at a time.
    for (int i = 0; i < 7; i++) begin
      send8(ta[i], tb[i], tc[i], ts[i]);
      wait_drain8();
    end

    // Random operations issued back to back.
    for (int i = 0; i < 12; i++)
      send8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    wait_drain8();

    // Backpressure: result must hold while new requests are offered.
    done_ready = 1'b0;
    send8(8'h12, 8'h34, 1'b0, 1'b0);
    r = model(W, 64'h12, 64'h34, 1'b0, 1'b0);
    n = 0;
    while (!done_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_done_seen", {63'd0, done_valid}, 64'd1);
    repeat (10) begin
      @(posedge clk);
      #1;
      start_valid = 1'b1;
      a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      @(negedge clk);
      check("bp_start_ready", {63'd0, start_ready}, 64'd0);
      check("bp_done_valid",  {63'd0, done_valid},  64'd1);
      check("bp_hold",        {54'd0, cout, ovf, sum}, {54'd0, r[65:64], r[7:0]});
    end
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    done_ready  = 1'b1;
    wait_drain8();
    send8(8'h21, 8'h11, 1'b1, 1'b0);
    wait_drain8();

    // Asynchronous reset in the middle of RUN aborts the operation.
    send8(8'h55, 8'h22, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    check("mid_run_busy", {63'd0, busy}, 64'd1);
    rst8_n = 1'b0;
    #1;
    check("arst_done_valid", {63'd0, done_valid}, 64'd0);
    check("arst_busy",       {63'd0, busy},       64'd0);
    check("arst_sum",        {56'd0, sum},        64'd0);
    check("arst_state",      {62'd0, state8},     {62'd0, IDLE});
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    rst8_n = 1'b1;
    #1;
    check("arst_start_ready", {63'd0, start_ready}, 64'd1);
    send8(8'h05, 8'h03, 1'b0, 1'b0);
    wait_drain8();

    // Let the small instances finish their exhaustive sweeps.
    for (int k = 0; k < 20000 && !(g_small[0].fin && g_small[1].fin); k++) @(negedge clk);
    check("small_sweeps_done", {62'd0, g_small[1].fin, g_small[0].fin}, 64'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
